// File: rtl/rst_mon.sv
// rst_mon: monitors a synchronous active-high reset line, measures each assertion width,
// flags short/long violations, counts pulses and raises ready_o after release. Optional: RST_MON_ASSERT_EN.

`ifdef RST_MON_ASSERT_EN
module rst_mon_chk #(
  parameter int MIN_RST_CYCLES = 4,
  parameter int MAX_RST_CYCLES = 1024,
  parameter int WW             = 11
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          mon_rst_i,
  input logic          width_valid_i,
  input logic [WW-1:0] width_i
);
  // Simulation-only sanity checks on the monitored line and completed widths.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!$isunknown(mon_rst_i))
        else $fatal(1, "rst_mon: mon_rst_i is X/Z");
      if (width_valid_i) begin
        assert (int'(width_i) >= MIN_RST_CYCLES)
          else $error("rst_mon: short reset, width %0d", width_i);
        assert (int'(width_i) <= MAX_RST_CYCLES)
          else $error("rst_mon: long reset, width %0d", width_i);
      end
    end
  end
endmodule
`endif

module rst_mon #(
  parameter int MIN_RST_CYCLES = 4,
  parameter int MAX_RST_CYCLES = 1024,
  parameter int READY_DELAY    = 2,
  localparam int WW            = $clog2(MAX_RST_CYCLES + 2)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          mon_rst_i,
  input  logic          clr_err_i,
  output logic          ready_o,
  output logic [WW-1:0] width_o,
  output logic          width_valid_o,
  output logic [7:0]    pulses_o,
  output logic          err_short_o,
  output logic          err_long_o
);

  localparam int SW = $clog2(READY_DELAY + 2);

  localparam logic [WW-1:0] W_ONE = WW'(1);
  localparam logic [WW-1:0] W_MIN = WW'(MIN_RST_CYCLES);
  localparam logic [WW-1:0] W_MAX = WW'(MAX_RST_CYCLES);
  localparam logic [WW-1:0] W_SAT = WW'(MAX_RST_CYCLES + 1);
  localparam logic [SW-1:0] C_ONE = SW'(1);
  localparam logic [SW-1:0] C_DLY = SW'(READY_DELAY);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IN_RST = 2'd1,
    ST_SETTLE = 2'd2,
    ST_READY  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic            ready_q, ready_d;
  logic [WW-1:0]   width_q, width_d;
  logic            wvalid_q, wvalid_d;
  logic [7:0]      pulses_q, pulses_d;
  logic            err_short_q, err_short_d;
  logic            err_long_q, err_long_d;
  logic            set_short, set_long;

  // Next-state, measurement and flag logic.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    scnt_d    = scnt_q;
    width_d   = width_q;
    wvalid_d  = 1'b0;
    pulses_d  = pulses_q;
    set_short = 1'b0;
    set_long  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mon_rst_i) begin
          state_d = ST_IN_RST;
          wcnt_d  = W_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IN_RST: begin
        if (mon_rst_i) begin
          // Width saturates one past the limit so an overlong pulse stays visible.
          if (wcnt_q != W_SAT) begin
            wcnt_d   = wcnt_q + W_ONE;
            set_long = (wcnt_q == W_MAX);
          end else begin
            wcnt_d = wcnt_q;
          end
        end else begin
          width_d   = wcnt_q;
          wvalid_d  = 1'b1;
          set_short = (wcnt_q < W_MIN);
          if (pulses_q != 8'hFF) begin
            pulses_d = pulses_q + 8'd1;
          end else begin
            pulses_d = pulses_q;
          end
          if (READY_DELAY == 0) begin
            state_d = ST_READY;
          end else begin
            state_d = ST_SETTLE;
            scnt_d  = C_ONE;
          end
        end
      end
      ST_SETTLE: begin
        if (mon_rst_i) begin
          state_d = ST_IN_RST;
          wcnt_d  = W_ONE;
        end else if (scnt_q >= C_DLY) begin
          state_d = ST_READY;
        end else begin
          scnt_d = scnt_q + C_ONE;
        end
      end
      ST_READY: begin
        if (mon_rst_i) begin
          state_d = ST_IN_RST;
          wcnt_d  = W_ONE;
        end else begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A set event in the same cycle as a clear wins.
    err_short_d = set_short | (err_short_q & ~clr_err_i);
    err_long_d  = set_long  | (err_long_q  & ~clr_err_i);
    ready_d     = (state_d == ST_READY);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      scnt_q      <= '0;
      ready_q     <= 1'b0;
      width_q     <= '0;
      wvalid_q    <= 1'b0;
      pulses_q    <= 8'd0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      scnt_q      <= scnt_d;
      ready_q     <= ready_d;
      width_q     <= width_d;
      wvalid_q    <= wvalid_d;
      pulses_q    <= pulses_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end

  assign ready_o       = ready_q;
  assign width_o       = width_q;
  assign width_valid_o = wvalid_q;
  assign pulses_o      = pulses_q;
  assign err_short_o   = err_short_q;
  assign err_long_o    = err_long_q;

`ifdef RST_MON_ASSERT_EN
  rst_mon_chk #(
    .MIN_RST_CYCLES(MIN_RST_CYCLES),
    .MAX_RST_CYCLES(MAX_RST_CYCLES),
    .WW            (WW)
  ) u_chk (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .mon_rst_i    (mon_rst_i),
    .width_valid_i(wvalid_q),
    .width_i      (width_q)
  );
`else
  // Checker not built; flags and behaviour are unchanged.
`endif

endmodule

// File: tb/tb_rst_mon.sv
// Directed bench for rst_mon: a default instance plus one with MAX_RST_CYCLES=8 share stimulus.
module tb_rst_mon;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mon = 1'b0;
  logic        clr = 1'b0;

  logic        rdy, wv, es, el;
  logic [10:0] wid;
  logic [7:0]  pul;
  logic        rdy8, wv8, es8, el8;
  logic [3:0]  wid8;
  logic [7:0]  pul8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rst_mon u_dut (
    .clk_i(clk), .rst_i(rst), .mon_rst_i(mon), .clr_err_i(clr),
    .ready_o(rdy), .width_o(wid), .width_valid_o(wv), .pulses_o(pul),
    .err_short_o(es), .err_long_o(el)
  );

  rst_mon #(.MAX_RST_CYCLES(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .mon_rst_i(mon), .clr_err_i(clr),
    .ready_o(rdy8), .width_o(wid8), .width_valid_o(wv8), .pulses_o(pul8),
    .err_short_o(es8), .err_long_o(el8)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check_eq("rst_ready", 32'(rdy), 32'd0);
    check_eq("rst_width", 32'(wid), 32'd0);
    check_eq("rst_pulses", 32'(pul), 32'd0);
    check_eq("rst_errs", 32'({es, el, wv}), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("idle_ready", 32'(rdy), 32'd0);

    // 10-cycle legal pulse
    mon = 1'b1;
    repeat (10) tick();
    check_eq("t1_ready_in", 32'(rdy), 32'd0);
    mon = 1'b0;
    tick();
    check_eq("t1_width", 32'(wid), 32'd10);
    check_eq("t1_valid", 32'(wv), 32'd1);
    check_eq("t1_pulses", 32'(pul), 32'd1);
    check_eq("t1_errs", 32'({es, el}), 32'd0);
    check_eq("t1_ready_t", 32'(rdy), 32'd0);
    tick();
    check_eq("t1_valid_1cyc", 32'(wv), 32'd0);
    check_eq("t1_ready_t1", 32'(rdy), 32'd0);
    tick();
    check_eq("t1_ready_t2", 32'(rdy), 32'd1);

    // 2-cycle short pulse, sticky flag, clear
    mon = 1'b1;
    tick();
    check_eq("t2_ready_fall", 32'(rdy), 32'd0);
    tick();
    mon = 1'b0;
    tick();
    check_eq("t2_width", 32'(wid), 32'd2);
    check_eq("t2_short", 32'(es), 32'd1);
    check_eq("t2_pulses", 32'(pul), 32'd2);
    repeat (3) tick();
    check_eq("t2_short_sticky", 32'(es), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("t2_short_clr", 32'(es), 32'd0);

    // 20-cycle pulse: long on the MAX=8 instance
    mon = 1'b1;
    repeat (8) tick();
    check_eq("t3_long_8th", 32'(el8), 32'd0);
    tick();
    check_eq("t3_long_9th", 32'(el8), 32'd1);
    check_eq("t3_long_dflt", 32'(el), 32'd0);
    repeat (11) tick();
    mon = 1'b0;
    tick();
    check_eq("t3_width_sat", 32'(wid8), 32'd9);
    check_eq("t3_valid8", 32'(wv8), 32'd1);
    check_eq("t3_width_dflt", 32'(wid), 32'd20);
    check_eq("t3_pulses", 32'(pul), 32'd3);
    check_eq("t3_short8", 32'(es8), 32'd0);

    // Settle aborted by re-assertion one cycle after release
    mon = 1'b1;
    repeat (5) tick();
    mon = 1'b0;
    tick();
    check_eq("t4_width_a", 32'(wid), 32'd5);
    mon = 1'b1;
    tick();
    check_eq("t4_ready_abort", 32'(rdy), 32'd0);
    check_eq("t4_valid_abort", 32'(wv), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t4_ready_held", 32'(rdy), 32'd0);
    end
    mon = 1'b0;
    tick();
    check_eq("t4_width_b", 32'(wid), 32'd4);
    check_eq("t4_pulses", 32'(pul), 32'd5);
    check_eq("t4_short", 32'(es), 32'd0);
    tick();
    check_eq("t4_ready_t1", 32'(rdy), 32'd0);
    tick();
    check_eq("t4_ready_t2", 32'(rdy), 32'd1);

    // 300 legal pulses saturate the counter
    for (int i = 0; i < 300; i++) begin
      mon = 1'b1;
      repeat (4) tick();
      mon = 1'b0;
      tick();
    end
    check_eq("t5_pulses_sat", 32'(pul), 32'd255);
    check_eq("t5_width", 32'(wid), 32'd4);
    check_eq("t5_short", 32'(es), 32'd0);

    // Clear coinciding with a short release: set wins
    mon = 1'b1;
    tick();
    mon = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("t5_set_wins", 32'(es), 32'd1);
    check_eq("t5_width_1", 32'(wid), 32'd1);
    check_eq("t5_pulses_hold", 32'(pul), 32'd255);

    // Block reset mid-assertion
    mon = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_eq("t6_ready", 32'(rdy), 32'd0);
    check_eq("t6_width", 32'(wid), 32'd0);
    check_eq("t6_pulses", 32'(pul), 32'd0);
    check_eq("t6_flags", 32'({es, el, wv}), 32'd0);
    check_eq("t6_long8", 32'(el8), 32'd0);
    rst = 1'b0;
    repeat (4) tick();
    mon = 1'b0;
    tick();
    check_eq("t6_width_restart", 32'(wid), 32'd4);
    check_eq("t6_pulses_restart", 32'(pul), 32'd1);
    check_eq("t6_valid", 32'(wv), 32'd1);
    check_eq("t6_errs", 32'({es, el}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
